// File: rtl/skid_adder_stage.sv
// skid_adder_stage
//   Elastic valid/ready stage that adds a constant INCREMENT to every accepted
//   item (modulo 2**WIDTH) and carries the addition's carry-out alongside it.
//   Two storage entries (main + skid) let this_ready be a pure flop output,
//   so no combinational path exists from next_ready back to this_ready.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous reset, active low
//   prev_valid     upstream item present on input_num
//   this_ready     stage can accept this cycle (registered)
//   this_valid     output_num/overflow_out hold an item (registered)
//   next_ready     downstream takes the item this cycle
//   input_num      upstream data
//   output_num     stored (item + INCREMENT) mod 2**WIDTH
//   overflow_out   carry-out of that addition
//   accepted_count items accepted since reset, wraps
module skid_adder_stage #(
    parameter int WIDTH     = 5,
    parameter int INCREMENT = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prev_valid,
    output logic                 this_ready,
    output logic                 this_valid,
    input  logic                 next_ready,
    input  logic [WIDTH-1:0]     input_num,
    output logic [WIDTH-1:0]     output_num,
    output logic                 overflow_out,
    output logic [CNT_WIDTH-1:0] accepted_count
);

    localparam logic [WIDTH-1:0] INC_T = WIDTH'(INCREMENT);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_valid;
    logic                 r_ready;
    logic [WIDTH-1:0]     r_main_num;
    logic                 r_main_ovf;
    logic [WIDTH-1:0]     r_skid_num;
    logic                 r_skid_ovf;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_accept;
    logic                 w_emit;
    logic [WIDTH:0]       w_sum;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_skid_to_main;

    assign w_accept = prev_valid && r_ready;
    assign w_emit   = r_valid && next_ready;
    // Carry-out lands in the top bit.
    assign w_sum    = {1'b0, input_num} + {1'b0, INC_T};

    always_comb begin
        w_next_state   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state = ONE;
                    w_load_main  = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_emit) begin
                    w_next_state = TWO;
                    w_load_skid  = 1'b1;
                end else if (w_accept && w_emit) begin
                    // Old head leaves while the new item takes its place.
                    w_load_main  = 1'b1;
                end else if (w_emit) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                // r_ready is low here, so nothing can be accepted.
                if (w_emit) begin
                    w_next_state   = ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_main_num <= '0;
            r_main_ovf <= 1'b0;
            r_skid_num <= '0;
            r_skid_ovf <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state <= w_next_state;
            // Flags are derived from the next state so they are flop outputs.
            r_valid <= (w_next_state != EMPTY);
            r_ready <= (w_next_state != TWO);
            if (w_load_main) begin
                r_main_num <= w_sum[WIDTH-1:0];
                r_main_ovf <= w_sum[WIDTH];
            end else if (w_skid_to_main) begin
                r_main_num <= r_skid_num;
                r_main_ovf <= r_skid_ovf;
            end
            if (w_load_skid) begin
                r_skid_num <= w_sum[WIDTH-1:0];
                r_skid_ovf <= w_sum[WIDTH];
            end
            if (w_accept) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign this_ready     = r_ready;
    assign this_valid     = r_valid;
    assign output_num     = r_main_num;
    assign overflow_out   = r_main_ovf;
    assign accepted_count = r_count;

endmodule

// File: tb/tb_skid_adder_stage.sv
module tb_skid_adder_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       prev_valid;
    logic       this_ready;
    logic       this_valid;
    logic       next_ready;
    logic [4:0] input_num;
    logic [4:0] output_num;
    logic       overflow_out;
    logic [7:0] accepted_count;

    int tests  = 0;
    int failed = 0;

    skid_adder_stage #(.WIDTH(5), .INCREMENT(1), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .prev_valid     (prev_valid),
        .this_ready     (this_ready),
        .this_valid     (this_valid),
        .next_ready     (next_ready),
        .input_num      (input_num),
        .output_num     (output_num),
        .overflow_out   (overflow_out),
        .accepted_count (accepted_count)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; prev_valid = 1'b0; next_ready = 1'b0; input_num = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; prev_valid = 1'b1; next_ready = 1'b1; input_num = 5'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({this_valid, this_ready, output_num, overflow_out, accepted_count} !== 16'h0) begin
                failed++;
                $display("FAIL reset_hold cyc%0d: v=%b r=%b out=%0d ovf=%b cnt=%0d, want all 0",
                         i, this_valid, this_ready, output_num, overflow_out, accepted_count);
            end
        end
        reset = 1'b1;
        step();
        tests++;
        if (this_ready !== 1'b1 || this_valid !== 1'b0 || accepted_count !== 8'd0) begin
            failed++;
            $display("FAIL reset_release: r=%b v=%b cnt=%0d, want r=1 v=0 cnt=0",
                     this_ready, this_valid, accepted_count);
        end
        step();
        tests++;
        if (this_valid !== 1'b1 || output_num !== 5'd6 || accepted_count !== 8'd1) begin
            failed++;
            $display("FAIL reset_first_accept: v=%b out=%0d cnt=%0d, want v=1 out=6 cnt=1",
                     this_valid, output_num, accepted_count);
        end
        prev_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        next_ready = 1'b1;
        prev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            input_num = 5'(i);
            step();
            tests++;
            if (this_valid !== 1'b1 || output_num !== 5'(i + 1) || this_ready !== 1'b1) begin
                failed++;
                $display("FAIL b2b item%0d: v=%b r=%b out=%0d, want v=1 r=1 out=%0d",
                         i, this_valid, this_ready, output_num, i + 1);
            end
        end
        prev_valid = 1'b0;
        tests++;
        if (accepted_count !== 8'd4) begin
            failed++;
            $display("FAIL b2b_count: cnt=%0d, want 4", accepted_count);
        end
        step();
        tests++;
        if (this_valid !== 1'b0) begin
            failed++;
            $display("FAIL b2b_drain: v=%b, want 0", this_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        next_ready = 1'b0;
        prev_valid = 1'b1; input_num = 5'd7;
        step();
        tests++;
        if (this_valid !== 1'b1 || output_num !== 5'd8 || this_ready !== 1'b1) begin
            failed++;
            $display("FAIL bp_first: v=%b r=%b out=%0d, want v=1 r=1 out=8",
                     this_valid, this_ready, output_num);
        end
        input_num = 5'd9;
        step();
        prev_valid = 1'b0;
        tests++;
        if (this_ready !== 1'b0 || output_num !== 5'd8 || accepted_count !== 8'd2) begin
            failed++;
            $display("FAIL bp_full: r=%b out=%0d cnt=%0d, want r=0 out=8 cnt=2",
                     this_ready, output_num, accepted_count);
        end
        step();
        tests++;
        if (this_ready !== 1'b0 || this_valid !== 1'b1 || output_num !== 5'd8) begin
            failed++;
            $display("FAIL bp_hold: r=%b v=%b out=%0d, want r=0 v=1 out=8",
                     this_ready, this_valid, output_num);
        end
        next_ready = 1'b1;
        step();
        tests++;
        if (this_ready !== 1'b1 || this_valid !== 1'b1 || output_num !== 5'd10) begin
            failed++;
            $display("FAIL bp_second: r=%b v=%b out=%0d, want r=1 v=1 out=10",
                     this_ready, this_valid, output_num);
        end
        step();
        tests++;
        if (this_valid !== 1'b0) begin
            failed++;
            $display("FAIL bp_drain: v=%b, want 0", this_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        next_ready = 1'b1;
        prev_valid = 1'b1; input_num = 5'd31;
        step();
        tests++;
        if (output_num !== 5'd0 || overflow_out !== 1'b1 || this_valid !== 1'b1) begin
            failed++;
            $display("FAIL wrap_31: out=%0d ovf=%b v=%b, want out=0 ovf=1 v=1",
                     output_num, overflow_out, this_valid);
        end
        input_num = 5'd30;
        step();
        tests++;
        if (output_num !== 5'd31 || overflow_out !== 1'b0 || this_valid !== 1'b1) begin
            failed++;
            $display("FAIL wrap_30: out=%0d ovf=%b v=%b, want out=31 ovf=0 v=1",
                     output_num, overflow_out, this_valid);
        end
        prev_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_two();
        do_reset();
        next_ready = 1'b0;
        prev_valid = 1'b1; input_num = 5'd3;
        step();
        input_num = 5'd4;
        step();
        prev_valid = 1'b0;
        tests++;
        if (this_ready !== 1'b0 || this_valid !== 1'b1 || accepted_count !== 8'd2) begin
            failed++;
            $display("FAIL two_setup: r=%b v=%b cnt=%0d, want r=0 v=1 cnt=2",
                     this_ready, this_valid, accepted_count);
        end
        reset = 1'b0;
        step();
        tests++;
        if (this_valid !== 1'b0 || this_ready !== 1'b0 || accepted_count !== 8'd0 || output_num !== 5'd0) begin
            failed++;
            $display("FAIL two_reset: v=%b r=%b cnt=%0d out=%0d, want all 0",
                     this_valid, this_ready, accepted_count, output_num);
        end
        reset = 1'b1; next_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (this_valid !== 1'b0 || this_ready !== 1'b1) begin
                failed++;
                $display("FAIL two_no_stale cyc%0d: v=%b r=%b, want v=0 r=1",
                         i, this_valid, this_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] q[$];
        logic [5:0] e;
        logic [7:0] cnt_m;
        logic       acc, emt, hold;
        logic [5:0] held;
        do_reset();
        cnt_m = '0;
        hold  = 1'b0;
        held  = '0;
        for (int c = 0; c < 10000; c++) begin
            tests++;
            if (this_valid !== (q.size() != 0) || this_ready !== (q.size() < 2)) begin
                failed++;
                $display("FAIL rnd_flags cyc%0d: v=%b r=%b, want v=%b r=%b",
                         c, this_valid, this_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                tests++;
                if ({overflow_out, output_num} !== q[0]) begin
                    failed++;
                    $display("FAIL rnd_data cyc%0d: ovf=%b out=%0d, want ovf=%b out=%0d",
                             c, overflow_out, output_num, q[0][5], q[0][4:0]);
                end
            end
            if (hold) begin
                tests++;
                if ({overflow_out, output_num} !== held) begin
                    failed++;
                    $display("FAIL rnd_stable cyc%0d: got %0h, want %0h",
                             c, {overflow_out, output_num}, held);
                end
            end
            tests++;
            if (accepted_count !== cnt_m) begin
                failed++;
                $display("FAIL rnd_count cyc%0d: cnt=%0d, want %0d", c, accepted_count, cnt_m);
            end
            prev_valid = 1'($urandom_range(0, 1));
            next_ready = ($urandom_range(0, 3) != 0);
            input_num  = 5'($urandom_range(0, 31));
            acc  = prev_valid && (q.size() < 2);
            emt  = next_ready && (q.size() != 0);
            hold = (q.size() != 0) && !next_ready;
            held = {overflow_out, output_num};
            e    = {1'b0, input_num} + 6'd1;
            step();
            if (emt) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                cnt_m = cnt_m + 8'd1;
            end
        end
        prev_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; prev_valid = 1'b0; next_ready = 1'b0; input_num = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_in_two();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
